// File: rtl/image_frame_streamer.sv
// image_frame_streamer: streams one stored image, a row per cycle,
// from an internal synchronous ROM over a valid/ready handshake.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   sel                image index, latched at frame start (and at
//                      each wrap in continuous mode)
//   start              raw push-button; rising edge starts a frame
//   mode               0 = single frame, 1 = continuous
//   abort              synchronous stop, drops the in-flight row
//   ready_i            downstream accepts when valid_o & ready_i
//   data_o             current row, pixel 0 in the LSBs
//   valid_o            data_o/row_o/sof_o/eof_o valid
//   row_o              row index of data_o
//   sof_o, eof_o       first / last row markers
//   busy_o             frame in progress
//   frame_done_o       pulse: last row of a single frame accepted
//   err_o              pulse: start with sel >= N_IMG
//
// ROM words are N_IMG*H rows of W*PIX bits, image-major. The table
// is a generated pattern keyed on the last character of INIT_FILE;
// pixels 0 and 1 of each word carry the word's own address.
module image_frame_streamer #(
    parameter int W = 24,
    parameter int H = 24,
    parameter int PIX = 8,
    parameter int N_IMG = 16,
    parameter int SEL_W = 4,
    parameter logic [127:0] INIT_FILE = "images.txt",
    localparam int RW = (H > 1) ? $clog2(H) : 1,
    localparam int D = W * PIX
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [SEL_W-1:0] sel,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             ready_i,
    output logic [D-1:0]     data_o,
    output logic             valid_o,
    output logic [RW-1:0]    row_o,
    output logic             sof_o,
    output logic             eof_o,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             err_o
);

    localparam int DEPTH = N_IMG * H;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = (N_IMG > 1) ? $clog2(N_IMG) : 1;
    localparam logic [7:0] KEY = INIT_FILE[7:0];

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    function automatic logic [D-1:0] rom_word(input int a);
        logic [D-1:0] w;
        int v;
        w = '0;
        for (int p = 0; p < W; p++) begin
            if (p == 0)
                v = a;
            else if (p == 1)
                v = a >> PIX;
            else
                v = a * W + p + int'(KEY);
            w[p*PIX +: PIX] = PIX'(v);
        end
        return w;
    endfunction

    logic [D-1:0] rom [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = rom_word(g);
    end

    state_t         state, state_n;
    logic [IW-1:0]  img, img_n;
    logic           mode_r, mode_n;
    logic [RW-1:0]  row_cnt, row_n;
    logic           err_n, done_n;
    logic           s1, s2, s3;
    logic           start_edge;
    logic           sel_ok;
    logic           en;
    logic           issue;
    logic           last;
    logic [AW-1:0]  addr;

    // Sync flops reset high so a button held through reset
    // does not look like a fresh press.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= start;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign start_edge = s2 & ~s3;
    assign sel_ok = (int'(sel) < N_IMG);
    assign en = ~valid_o | ready_i;
    assign issue = (state == RUN);
    assign last = (row_cnt == RW'(H - 1));
    assign addr = AW'(int'(img) * H + int'(row_cnt));

    always_comb begin
        state_n = state;
        img_n = img;
        mode_n = mode_r;
        row_n = row_cnt;
        err_n = 1'b0;
        done_n = 1'b0;
        if (abort) begin
            state_n = IDLE;
            row_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_edge) begin
                        if (sel_ok) begin
                            state_n = RUN;
                            img_n = IW'(sel);
                            mode_n = mode;
                            row_n = '0;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        if (last) begin
                            row_n = '0;
                            if (mode_r) begin
                                // Wrap with no bubble; a bad sel
                                // keeps the current image.
                                if (sel_ok)
                                    img_n = IW'(sel);
                                mode_n = mode;
                            end else begin
                                state_n = DRAIN;
                            end
                        end else begin
                            row_n = row_cnt + RW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (valid_o && ready_i) begin
                        state_n = IDLE;
                        done_n = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            img <= '0;
            mode_r <= 1'b0;
            row_cnt <= '0;
            err_o <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            state <= state_n;
            img <= img_n;
            mode_r <= mode_n;
            row_cnt <= row_n;
            err_o <= err_n;
            frame_done_o <= done_n;
        end
    end

    // Output stage holds while stalled (en = 0).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_o <= 1'b0;
            row_o <= '0;
        end else if (abort) begin
            valid_o <= 1'b0;
        end else if (en) begin
            valid_o <= issue;
            row_o <= row_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (en)
            data_o <= rom[addr];
    end

    assign busy_o = (state != IDLE);
    assign sof_o = valid_o & (row_o == '0);
    assign eof_o = valid_o & (row_o == RW'(H - 1));

endmodule

// File: tb/tb_image_frame_streamer.sv
// Bench for image_frame_streamer: scoreboard of expected rows,
// checked on every handshake, plus per-scenario timing checks.
module tb_image_frame_streamer;

    localparam int W = 24;
    localparam int H = 24;
    localparam int PIX = 8;
    localparam int N_IMG = 16;
    localparam int SEL_W = 5;
    localparam int D = W * PIX;
    localparam int RW = 5;
    // Last character of the default INIT_FILE, "images.txt".
    localparam logic [7:0] KEY = 8'h74;

    logic             clk = 1'b0;
    logic             rstn;
    logic [SEL_W-1:0] sel;
    logic             start;
    logic             mode;
    logic             abort;
    logic             ready_i;
    logic [D-1:0]     data_o;
    logic             valid_o;
    logic [RW-1:0]    row_o;
    logic             sof_o;
    logic             eof_o;
    logic             busy_o;
    logic             frame_done_o;
    logic             err_o;

    always #5 clk = ~clk;

    image_frame_streamer #(
        .W(W), .H(H), .PIX(PIX), .N_IMG(N_IMG), .SEL_W(SEL_W)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .sel(sel),
        .start(start),
        .mode(mode),
        .abort(abort),
        .ready_i(ready_i),
        .data_o(data_o),
        .valid_o(valid_o),
        .row_o(row_o),
        .sof_o(sof_o),
        .eof_o(eof_o),
        .busy_o(busy_o),
        .frame_done_o(frame_done_o),
        .err_o(err_o)
    );

    typedef struct {
        logic [D-1:0] data;
        int           row;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit mon_on = 1'b0;
    bit prev_stall = 1'b0;
    bit run_bp = 1'b0;
    logic [D-1:0] prev_data;
    logic [RW-1:0] prev_row;

    function automatic logic [D-1:0] img_word(input int a);
        logic [D-1:0] w;
        logic [7:0] px;
        w = '0;
        for (int p = 0; p < W; p++) begin
            case (p)
                0: px = a[7:0];
                1: px = a[15:8];
                default: px = 8'(a * W + p + int'(KEY));
            endcase
            w[p*8 +: 8] = px;
        end
        return w;
    endfunction

    task automatic push_rows(input int img, input int n);
        exp_t x;
        for (int r = 0; r < n; r++) begin
            x.data = img_word(img * H + r);
            x.row = r;
            exp_q.push_back(x);
        end
    endtask

    // Scoreboard monitor: every handshake pops one expected row;
    // a stalled row must stay put until accepted.
    always @(negedge clk) begin
        if (!mon_on) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (valid_o !== 1'b1 || data_o !== prev_data ||
                    row_o !== prev_row) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b row=%0d, want valid=1 row=%0d",
                             valid_o, row_o, prev_row);
                end
            end
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                hs_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_row: got row=%0d, want no row", row_o);
                end else begin
                    e = exp_q.pop_front();
                    if (data_o !== e.data || row_o !== RW'(e.row) ||
                        sof_o !== (e.row == 0) ||
                        eof_o !== (e.row == H - 1)) begin
                        errors++;
                        $display("FAIL row_data: got row=%0d sof=%b eof=%b data=%h, want row=%0d data=%h",
                                 row_o, sof_o, eof_o, data_o, e.row, e.data);
                    end
                end
            end
            prev_stall = (valid_o === 1'b1) && (ready_i !== 1'b1);
            prev_data = data_o;
            prev_row = row_o;
            if (frame_done_o === 1'b1)
                done_cnt++;
            if (err_o === 1'b1)
                err_cnt++;
        end
    end

    task automatic press();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit, input string tag);
        int n;
        n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done: no frame_done_o within %0d cycles", tag, limit);
        end
    endtask

    task automatic wait_row(input int r, input int limit, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(valid_o === 1'b1 && row_o == RW'(r)) && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            errors++;
            $display("FAIL %s_row%0d: row not seen within %0d cycles", tag, r, limit);
        end
    endtask

    task automatic check_q_empty(input string tag);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_rows: %0d rows undelivered, want 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start = 1'b1;
        sel = '0;
        mode = 1'b0;
        abort = 1'b0;
        ready_i = 1'b1;
        #12;
        checks++;
        if ({valid_o, busy_o, row_o, sof_o, eof_o, frame_done_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b b=%b row=%0d sof=%b eof=%b fd=%b err=%b, want all 0",
                     valid_o, busy_o, row_o, sof_o, eof_o, frame_done_o, err_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        mon_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_held_start: busy=%b valid=%b, want 0 0", busy_o, valid_o);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        int d0;
        bit vx, bx, fx;
        d0 = done_cnt;
        push_rows(3, H);
        sel = 5'd3;
        mode = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 4)
                start = 1'b0;
            vx = (k >= 3 && k <= 26);
            bx = (k >= 2 && k <= 26);
            fx = (k == 27);
            checks++;
            if (valid_o !== vx || busy_o !== bx || frame_done_o !== fx) begin
                errors++;
                $display("FAIL single_timing: edge k+%0d valid=%b busy=%b fd=%b, want %b %b %b",
                         k, valid_o, busy_o, frame_done_o, vx, bx, fx);
            end
        end
        check_q_empty("single");
        checks++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL single_done_count: got %0d, want %0d", done_cnt - d0, 1);
        end
    endtask

    task automatic test_backpressure();
        int d0, h0;
        d0 = done_cnt;
        h0 = hs_cnt;
        push_rows(7, H);
        sel = 5'd7;
        mode = 1'b0;
        run_bp = 1'b1;
        fork
            begin
                while (run_bp) begin
                    @(posedge clk);
                    #1 ready_i = 1'($urandom_range(0, 1));
                end
            end
            begin
                press();
                wait_done(d0, 400, "bp");
                run_bp = 1'b0;
            end
        join
        ready_i = 1'b1;
        check_q_empty("bp");
        checks++;
        if (hs_cnt - h0 != H) begin
            errors++;
            $display("FAIL bp_handshakes: got %0d, want %0d", hs_cnt - h0, H);
        end
    endtask

    task automatic test_continuous();
        int n, gaps;
        push_rows(2, H);
        push_rows(5, H);
        push_rows(5, H);
        sel = 5'd2;
        mode = 1'b1;
        press();
        n = 0;
        @(negedge clk);
        while (valid_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        gaps = 0;
        for (int i = 0; i < 3 * H; i++) begin
            if (valid_o !== 1'b1)
                gaps++;
            if (i == 10)
                sel = 5'd5;
            if (i == 30)
                mode = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (gaps != 0) begin
            errors++;
            $display("FAIL cont_bubbles: got %0d idle cycles, want 0", gaps);
        end
        checks++;
        if (valid_o !== 1'b0 || frame_done_o !== 1'b1) begin
            errors++;
            $display("FAIL cont_end: valid=%b fd=%b, want 0 1", valid_o, frame_done_o);
        end
        check_q_empty("cont");
    endtask

    task automatic test_error();
        int e0;
        bit ex;
        e0 = err_cnt;
        sel = 5'd16;
        mode = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1)
                start = 1'b0;
            ex = (k == 2);
            checks++;
            if (err_o !== ex || busy_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL bad_sel: edge k+%0d err=%b busy=%b valid=%b, want %b 0 0",
                         k, err_o, busy_o, valid_o, ex);
            end
        end
        checks++;
        if (err_cnt != e0 + 1) begin
            errors++;
            $display("FAIL bad_sel_pulses: got %0d, want 1", err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        push_rows(1, H);
        sel = 5'd1;
        mode = 1'b0;
        press();
        wait_row(5, 40, "b2b");
        sel = 5'd4;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(d0, 100, "b2b");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL b2b_restart: busy=%b valid=%b, want 0 0", busy_o, valid_o);
            end
        end
        check_q_empty("b2b");
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        push_rows(6, 11);
        sel = 5'd6;
        mode = 1'b0;
        press();
        wait_row(8, 40, "abort");
        start = 1'b1;
        wait_row(10, 10, "abort");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: valid=%b busy=%b, want 0 0", valid_o, busy_o);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt != d0 || valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: fd=%0d valid=%b busy=%b, want 0 0 0",
                     done_cnt - d0, valid_o, busy_o);
        end
        check_q_empty("abort");
        // Abort coinciding with a start edge while idle.
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle_start: busy=%b valid=%b, want 0 0", busy_o, valid_o);
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        push_rows(6, H);
        press();
        wait_done(d0, 100, "abort_restart");
        check_q_empty("abort_restart");
    endtask

    task automatic test_reset_mid();
        int d0;
        push_rows(9, H);
        sel = 5'd9;
        mode = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        wait_row(12, 40, "rst");
        #2 rstn = 1'b0;
        mon_on = 1'b0;
        #1;
        checks++;
        if ({valid_o, busy_o, row_o, sof_o, eof_o, frame_done_o, err_o} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got v=%b b=%b row=%0d sof=%b eof=%b, want all 0",
                     valid_o, busy_o, row_o, sof_o, eof_o);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        mon_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_held_start: busy=%b valid=%b, want 0 0", busy_o, valid_o);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        push_rows(9, H);
        press();
        wait_done(d0, 100, "rst_restart");
        check_q_empty("rst_restart");
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_continuous();
        test_error();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
